// File: rtl/cic_interpolator.sv
// ---------------------------------------------------------------------------
// cic_interpolator
//
// Multi-stage CIC interpolation filter. It takes one signed sample every RATE
// clocks, runs STAGES comb sections at the low rate, zero-stuffs by RATE, and
// runs STAGES integrators at the clock rate. Its output has unity DC gain.
//
// Parameters
//   WIDTH  - input/output sample width, signed two's complement
//   STAGES - number of comb sections and of integrator sections (>= 1)
//   RATE   - interpolation factor, a power of two (>= 2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_data    in   low-rate input sample
//   in_valid   in   in_data is valid
//   in_ready   out  sample taken this cycle (one cycle in every RATE)
//   out_data   out  high-rate output sample
//   out_valid  out  out_data is a meaningful sample
//   underrun   out  sticky: a ready slot passed without a valid input
//
// Handshake: a sample transfers on any rising edge where in_ready is high.
// in_ready does not wait for in_valid. If in_valid is low in that cycle, the
// slot still passes and the filter takes a zero. The output has no
// backpressure: a new sample is presented every clock.
//
// Optional feature macro: CIC_INTERP_UNDERRUN_EN
//   Defined     - underrun is a sticky flag, and the rate/ready assertions are
//                 compiled in.
//   Not defined - underrun is tied to 0. Missed slots still insert a zero.
// ---------------------------------------------------------------------------
module cic_interpolator #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int RATE   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             underrun
);

    localparam int L  = $clog2(RATE);
    // Bit growth of the cascade is RATE^(STAGES-1). The top WIDTH bits
    // therefore carry exactly unity DC gain.
    localparam int WI = WIDTH + (STAGES - 1) * L;

    logic [L-1:0]         ph_q;
    logic signed [WI-1:0] d_q [STAGES];
    logic signed [WI-1:0] d_d [STAGES];
    logic signed [WI-1:0] i_q [STAGES];
    logic signed [WI-1:0] i_d [STAGES];
    logic signed [WI-1:0] u_q;
    logic signed [WI-1:0] u_d;
    logic signed [WI-1:0] x;
    logic signed [WI-1:0] comb_v;
    // v_q[0]: a valid sample has been accepted. The higher bits delay that
    // event until the first sample reaches out_data.
    logic [STAGES:0]      v_q;
    logic [STAGES:0]      v_d;
    logic                 accept;

    assign in_ready = (ph_q == '0) & ~rst;
    assign accept   = in_ready;

    // A missed slot feeds a zero into the comb chain. It does not hold the
    // previous sample.
    always_comb begin
        x = '0;
        if (accept && in_valid) begin
            x = WI'($signed(in_data));
        end
    end

    // Comb chain: comb_v moves through c0..cN. Each delay captures the value
    // entering its stage, and only in an accept slot.
    always_comb begin
        comb_v = x;
        for (int k = 0; k < STAGES; k++) begin
            d_d[k] = accept ? comb_v : d_q[k];
            comb_v = comb_v - d_q[k];
        end
        u_d = accept ? comb_v : '0;
    end

    // Integrator cascade. Every stage uses the previous cycle's values.
    always_comb begin
        i_d[0] = i_q[0] + u_q;
        for (int k = 1; k < STAGES; k++) begin
            i_d[k] = i_q[k] + i_q[k-1];
        end
    end

    assign v_d = {v_q[STAGES-1:0], v_q[0] | (accept & in_valid)};

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q <= '0;
            u_q  <= '0;
            v_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                i_q[k] <= '0;
            end
        end else begin
            ph_q <= ph_q + 1'b1;
            u_q  <= u_d;
            v_q  <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
                i_q[k] <= i_d[k];
            end
        end
    end

    // Keeping only the top WIDTH bits truncates toward minus infinity.
    assign out_data  = i_q[STAGES-1][WI-1 -: WIDTH];
    assign out_valid = v_q[STAGES];

`ifdef CIC_INTERP_UNDERRUN_EN
    logic         underrun_q;
    logic [L-1:0] gap_q;
    logic         seen_q;

    // A missed slot counts only after the stream has started.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (accept && !in_valid && v_q[0]) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;

    // gap_q counts the cycles since the last ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q  <= '0;
            seen_q <= 1'b0;
        end else if (in_ready) begin
            gap_q  <= '0;
            seen_q <= 1'b1;
        end else begin
            gap_q  <= gap_q + 1'b1;
        end
    end

    a_rate_onehot: assert property (@(posedge clk) $onehot(RATE));

    a_ready_period: assert property (@(posedge clk) disable iff (rst)
        seen_q |-> (in_ready == (gap_q == L'(RATE - 1))));
`else
    assign underrun = 1'b0;
`endif

endmodule
